// File: rtl/cd_sdpram_arb.sv
// rtl/cd_sdpram_arb.sv - two-read/two-write client arbiter in front of a simple dual-port (or single-port) RAM
module cd_sdpram_arb #(
    parameter int A_WIDTH    = 8,
    parameter int D_WIDTH    = 8,
    parameter int SPRAM_ONLY = 0
) (
    input  logic               clk,
    input  logic               reset,

    input  logic               r0_req,
    input  logic [A_WIDTH-1:0] r0_addr,
    output logic               r0_gnt,
    output logic               r0_vld,

    input  logic               r1_req,
    input  logic [A_WIDTH-1:0] r1_addr,
    output logic               r1_gnt,
    output logic               r1_vld,

    output logic [D_WIDTH-1:0] rd_data,

    input  logic               w0_req,
    input  logic [A_WIDTH-1:0] w0_addr,
    input  logic [D_WIDTH-1:0] w0_data,
    output logic               w0_gnt,

    input  logic               w1_req,
    input  logic [A_WIDTH-1:0] w1_addr,
    input  logic [D_WIDTH-1:0] w1_data,
    output logic               w1_gnt,

    output logic               ram_cen,
    output logic               ram_wen,
    output logic [A_WIDTH-1:0] ram_ra,
    output logic [A_WIDTH-1:0] ram_wa,
    output logic [D_WIDTH-1:0] ram_wd,
    input  logic [D_WIDTH-1:0] ram_rd
);

    localparam logic SP = (SPRAM_ONLY != 0);

    // Round-robin state: rprio/wprio name the read/write client that wins a tie,
    // rwprio picks read (1) or write (0) when a single-port RAM is contested.
    logic rprio;
    logic wprio;
    logic rwprio;
    logic r0_vld_q;
    logic r1_vld_q;

    logic rd_pend;
    logic wr_pend;
    logic r_sel;
    logic w_sel;
    logic contested;
    logic rd_ok;
    logic wr_ok;

    // Arbitration: pick a read client and a write client, then resolve read vs write on a single port
    always_comb begin
        rd_pend   = r0_req | r1_req;
        wr_pend   = w0_req | w1_req;
        r_sel     = (r0_req & r1_req) ? rprio : r1_req;
        w_sel     = (w0_req & w1_req) ? wprio : w1_req;
        contested = SP & rd_pend & wr_pend;
        rd_ok     = rd_pend & ~reset & (~contested | rwprio);
        wr_ok     = wr_pend & ~reset & (~contested | ~rwprio);

        r0_gnt  = rd_ok & ~r_sel;
        r1_gnt  = rd_ok & r_sel;
        w0_gnt  = wr_ok & ~w_sel;
        w1_gnt  = wr_ok & w_sel;

        ram_cen = ~(rd_ok | wr_ok);
        ram_wen = ~wr_ok;
        // Idle cycles present client 0's fields; the RAM ignores them while disabled.
        ram_ra  = (rd_ok & r_sel) ? r1_addr : r0_addr;
        ram_wa  = (wr_ok & w_sel) ? w1_addr : w0_addr;
        ram_wd  = (wr_ok & w_sel) ? w1_data : w0_data;
    end

    // Priority rotation and read-valid pipeline; a read granted just before reset never reports valid
    always_ff @(posedge clk) begin
        if (reset) begin
            rprio    <= 1'b0;
            wprio    <= 1'b0;
            rwprio   <= 1'b0;
            r0_vld_q <= 1'b0;
            r1_vld_q <= 1'b0;
        end else begin
            if (rd_ok) begin
                rprio <= ~r_sel;
            end
            if (wr_ok) begin
                wprio <= ~w_sel;
            end
            if (contested) begin
                rwprio <= ~rwprio;
            end
            r0_vld_q <= r0_gnt;
            r1_vld_q <= r1_gnt;
        end
    end

    // Valid is masked by reset so every output sits at its reset value while reset is high.
    assign r0_vld  = r0_vld_q & ~reset;
    assign r1_vld  = r1_vld_q & ~reset;
    assign rd_data = ram_rd;

endmodule

// File: tb/tb_cd_sdpram_arb.sv
// tb/tb_cd_sdpram_arb.sv - directed and random checks of cd_sdpram_arb in dual-port and single-port modes
module tb_cd_sdpram_arb;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       r0_req = 1'b0, r1_req = 1'b0, w0_req = 1'b0, w1_req = 1'b0;
    logic [7:0] r0_addr = '0, r1_addr = '0, w0_addr = '0, w1_addr = '0;
    logic [7:0] w0_data = '0, w1_data = '0;

    logic       r0_gnt_a, r1_gnt_a, r0_vld_a, r1_vld_a, w0_gnt_a, w1_gnt_a, ram_cen_a, ram_wen_a;
    logic [7:0] rd_data_a, ram_ra_a, ram_wa_a, ram_wd_a, ram_rd_a;
    logic       r0_gnt_b, r1_gnt_b, r0_vld_b, r1_vld_b, w0_gnt_b, w1_gnt_b, ram_cen_b, ram_wen_b;
    logic [7:0] rd_data_b, ram_ra_b, ram_wa_b, ram_wd_b, ram_rd_b;

    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];
    logic [7:0] ref_mem [256];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cd_sdpram_arb #(.A_WIDTH(8), .D_WIDTH(8), .SPRAM_ONLY(0)) dut_a (
        .clk(clk), .reset(reset),
        .r0_req(r0_req), .r0_addr(r0_addr), .r0_gnt(r0_gnt_a), .r0_vld(r0_vld_a),
        .r1_req(r1_req), .r1_addr(r1_addr), .r1_gnt(r1_gnt_a), .r1_vld(r1_vld_a),
        .rd_data(rd_data_a),
        .w0_req(w0_req), .w0_addr(w0_addr), .w0_data(w0_data), .w0_gnt(w0_gnt_a),
        .w1_req(w1_req), .w1_addr(w1_addr), .w1_data(w1_data), .w1_gnt(w1_gnt_a),
        .ram_cen(ram_cen_a), .ram_wen(ram_wen_a), .ram_ra(ram_ra_a), .ram_wa(ram_wa_a),
        .ram_wd(ram_wd_a), .ram_rd(ram_rd_a)
    );

    cd_sdpram_arb #(.A_WIDTH(8), .D_WIDTH(8), .SPRAM_ONLY(1)) dut_b (
        .clk(clk), .reset(reset),
        .r0_req(r0_req), .r0_addr(r0_addr), .r0_gnt(r0_gnt_b), .r0_vld(r0_vld_b),
        .r1_req(r1_req), .r1_addr(r1_addr), .r1_gnt(r1_gnt_b), .r1_vld(r1_vld_b),
        .rd_data(rd_data_b),
        .w0_req(w0_req), .w0_addr(w0_addr), .w0_data(w0_data), .w0_gnt(w0_gnt_b),
        .w1_req(w1_req), .w1_addr(w1_addr), .w1_data(w1_data), .w1_gnt(w1_gnt_b),
        .ram_cen(ram_cen_b), .ram_wen(ram_wen_b), .ram_ra(ram_ra_b), .ram_wa(ram_wa_b),
        .ram_wd(ram_wd_b), .ram_rd(ram_rd_b)
    );

    // Behavioural RAMs: read-before-write, data one cycle after the enabled edge
    always @(posedge clk) begin
        if (!ram_cen_a) begin
            ram_rd_a <= mem_a[ram_ra_a];
            if (!ram_wen_a) mem_a[ram_wa_a] <= ram_wd_a;
        end
        if (!ram_cen_b) begin
            ram_rd_b <= mem_b[ram_ra_b];
            if (!ram_wen_b) mem_b[ram_wa_b] <= ram_wd_b;
        end
    end

    function automatic logic [3:0] gnts_a();
        return {w1_gnt_a, w0_gnt_a, r1_gnt_a, r0_gnt_a};
    endfunction

    function automatic logic [3:0] gnts_b();
        return {w1_gnt_b, w0_gnt_b, r1_gnt_b, r0_gnt_b};
    endfunction

    task automatic clear_reqs();
        r0_req = 1'b0; r1_req = 1'b0; w0_req = 1'b0; w1_req = 1'b0;
    endtask

    task automatic do_reset();
        clear_reqs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic ram_write(input logic [7:0] a, input logic [7:0] d);
        w0_req = 1'b1; w0_addr = a; w0_data = d;
        @(posedge clk);
        #1 w0_req = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        r0_req = 1'b1; r1_req = 1'b1; w0_req = 1'b1; w1_req = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        n_cmp++;
        if ({gnts_a(), ram_cen_a, ram_wen_a, r1_vld_a, r0_vld_a} !== 8'b0000_1100) begin
            n_err++;
            $display("FAIL reset_outputs_a: got %b expected 00001100",
                     {gnts_a(), ram_cen_a, ram_wen_a, r1_vld_a, r0_vld_a});
        end
        n_cmp++;
        if ({gnts_b(), ram_cen_b, ram_wen_b, r1_vld_b, r0_vld_b} !== 8'b0000_1100) begin
            n_err++;
            $display("FAIL reset_outputs_b: got %b expected 00001100",
                     {gnts_b(), ram_cen_b, ram_wen_b, r1_vld_b, r0_vld_b});
        end
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (gnts_a() !== 4'b0101) begin
            n_err++;
            $display("FAIL first_cycle_prio_a: got %b expected 0101", gnts_a());
        end
        n_cmp++;
        if (gnts_b() !== 4'b0100) begin
            n_err++;
            $display("FAIL first_cycle_prio_b: got %b expected 0100", gnts_b());
        end
        @(posedge clk);
        #1 clear_reqs();
    endtask

    task automatic test_read_arb();
        do_reset();
        ram_write(8'h10, 8'hA1);
        ram_write(8'h20, 8'hB2);
        do_reset();
        r0_req = 1'b1; r0_addr = 8'h10;
        r1_req = 1'b1; r1_addr = 8'h20;
        @(negedge clk);
        n_cmp++;
        if ({r1_gnt_a, r0_gnt_a, r1_vld_a, r0_vld_a} !== 4'b0100) begin
            n_err++;
            $display("FAIL read_arb_c0: got %b expected 0100", {r1_gnt_a, r0_gnt_a, r1_vld_a, r0_vld_a});
        end
        @(posedge clk);
        #1 r0_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({r1_gnt_a, r0_gnt_a, r1_vld_a, r0_vld_a} !== 4'b1001) begin
            n_err++;
            $display("FAIL read_arb_c1: got %b expected 1001", {r1_gnt_a, r0_gnt_a, r1_vld_a, r0_vld_a});
        end
        n_cmp++;
        if (rd_data_a !== 8'hA1) begin
            n_err++;
            $display("FAIL read_data_r0: got %h expected a1", rd_data_a);
        end
        @(posedge clk);
        #1 r1_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({r1_gnt_a, r0_gnt_a, r1_vld_a, r0_vld_a} !== 4'b0010) begin
            n_err++;
            $display("FAIL read_arb_c2: got %b expected 0010", {r1_gnt_a, r0_gnt_a, r1_vld_a, r0_vld_a});
        end
        n_cmp++;
        if (rd_data_a !== 8'hB2) begin
            n_err++;
            $display("FAIL read_data_r1: got %h expected b2", rd_data_a);
        end
    endtask

    task automatic test_write_alternate();
        do_reset();
        w0_req = 1'b1; w0_addr = 8'h40; w0_data = 8'h11;
        w1_req = 1'b1; w1_addr = 8'h41; w1_data = 8'h22;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({w1_gnt_a, w0_gnt_a, ram_wen_a} !== ((i % 2 == 0) ? 3'b010 : 3'b100)) begin
                n_err++;
                $display("FAIL write_alt_cycle%0d: got w1,w0,wen=%b expected %b", i,
                         {w1_gnt_a, w0_gnt_a, ram_wen_a}, (i % 2 == 0) ? 3'b010 : 3'b100);
            end
            @(posedge clk);
            #1;
        end
        clear_reqs();
    endtask

    task automatic test_same_addr();
        do_reset();
        ram_write(8'h30, 8'h00);
        do_reset();
        r0_req = 1'b1; r0_addr = 8'h30;
        w0_req = 1'b1; w0_addr = 8'h30; w0_data = 8'h55;
        @(negedge clk);
        n_cmp++;
        if ({r0_gnt_a, w0_gnt_a, ram_cen_a, ram_wen_a} !== 4'b1100) begin
            n_err++;
            $display("FAIL same_addr_grants: got %b expected 1100", {r0_gnt_a, w0_gnt_a, ram_cen_a, ram_wen_a});
        end
        @(posedge clk);
        #1 w0_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({r0_vld_a, r0_gnt_a, rd_data_a} !== {2'b11, 8'h00}) begin
            n_err++;
            $display("FAIL same_addr_old: got vld,gnt,data=%b,%b,%h expected 1,1,00", r0_vld_a, r0_gnt_a, rd_data_a);
        end
        @(posedge clk);
        #1 r0_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({r0_vld_a, rd_data_a} !== {1'b1, 8'h55}) begin
            n_err++;
            $display("FAIL same_addr_new: got vld,data=%b,%h expected 1,55", r0_vld_a, rd_data_a);
        end
    endtask

    task automatic test_spram_alternate();
        do_reset();
        r0_req = 1'b1; r0_addr = 8'h10;
        w0_req = 1'b1; w0_addr = 8'h50; w0_data = 8'h77;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({r0_gnt_b, w0_gnt_b, ram_cen_b} !== ((i % 2 == 0) ? 3'b010 : 3'b100)) begin
                n_err++;
                $display("FAIL spram_alt_cycle%0d: got r0,w0,cen=%b expected %b", i,
                         {r0_gnt_b, w0_gnt_b, ram_cen_b}, (i % 2 == 0) ? 3'b010 : 3'b100);
            end
            @(posedge clk);
            #1;
        end
        clear_reqs();
    endtask

    task automatic test_reset_during_read();
        do_reset();
        r0_req = 1'b1; r0_addr = 8'h10;
        @(negedge clk);
        n_cmp++;
        if (r0_gnt_a !== 1'b1) begin
            n_err++;
            $display("FAIL reset_read_gnt: got %b expected 1", r0_gnt_a);
        end
        @(posedge clk);
        #1 reset = 1'b1; r0_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({r0_vld_a, r1_vld_a, gnts_a(), ram_cen_a, ram_wen_a} !== 8'b0000_0011) begin
            n_err++;
            $display("FAIL reset_read_in_reset: got %b expected 00000011",
                     {r0_vld_a, r1_vld_a, gnts_a(), ram_cen_a, ram_wen_a});
        end
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({r0_vld_a, r0_vld_b} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_read_after: got %b expected 00", {r0_vld_a, r0_vld_b});
        end
    endtask

    task automatic test_random(input bit spram, input int cycles);
        logic [3:0] rq;
        logic [7:0] ad [4];
        logic [7:0] dt [4];
        int         wt [4];
        logic [3:0] g;
        logic [1:0] v;
        logic [7:0] rd;
        logic [1:0] exp_v;
        logic [7:0] exp_d [2];
        int         bound;
        bound = spram ? 4 : 2;
        do_reset();
        for (int i = 0; i < 16; i++) ram_write(8'(8'h80 + i), 8'($urandom));
        rq = '0;
        exp_v = '0;
        exp_d[0] = '0; exp_d[1] = '0;
        for (int i = 0; i < 4; i++) begin
            wt[i] = 0; ad[i] = 8'h80; dt[i] = '0;
        end
        for (int c = 0; c <= cycles; c++) begin
            @(negedge clk);
            g  = spram ? gnts_b() : gnts_a();
            v  = spram ? {r1_vld_b, r0_vld_b} : {r1_vld_a, r0_vld_a};
            rd = spram ? rd_data_b : rd_data_a;
            n_cmp++;
            if (v !== exp_v) begin
                n_err++;
                $display("FAIL rand_vld sp=%0d cyc=%0d: got %b expected %b", spram, c, v, exp_v);
            end
            for (int k = 0; k < 2; k++) begin
                if (exp_v[k]) begin
                    n_cmp++;
                    if (rd !== exp_d[k]) begin
                        n_err++;
                        $display("FAIL rand_data sp=%0d cyc=%0d r%0d: got %h expected %h", spram, c, k, rd, exp_d[k]);
                    end
                end
            end
            n_cmp++;
            if (((g & ~rq) != 0) || (g[0] && g[1]) || (spram && $countones(g) > 1)) begin
                n_err++;
                $display("FAIL rand_grant_legal sp=%0d cyc=%0d: got gnt %b with req %b", spram, c, g, rq);
            end
            exp_v = g[1:0];
            exp_d[0] = ref_mem[ad[0]];
            exp_d[1] = ref_mem[ad[1]];
            if (g[2]) ref_mem[ad[2]] = dt[2];
            if (g[3]) ref_mem[ad[3]] = dt[3];
            for (int i = 0; i < 4; i++) begin
                if (rq[i]) wt[i]++;
                if (g[i]) begin
                    n_cmp++;
                    if (wt[i] > bound) begin
                        n_err++;
                        $display("FAIL rand_starve sp=%0d cyc=%0d client%0d: waited %0d bound %0d", spram, c, i, wt[i], bound);
                    end
                    wt[i] = 0;
                end else if (rq[i] && wt[i] >= bound) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL rand_starve sp=%0d cyc=%0d client%0d: waited %0d bound %0d", spram, c, i, wt[i], bound);
                    wt[i] = 0;
                end
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (g[i] || !rq[i]) begin
                    rq[i] = (c < cycles) && ($urandom_range(3) != 0);
                    ad[i] = 8'(8'h80 + $urandom_range(15));
                    dt[i] = 8'($urandom);
                end
            end
            r0_req = rq[0]; r0_addr = ad[0];
            r1_req = rq[1]; r1_addr = ad[1];
            w0_req = rq[2]; w0_addr = ad[2]; w0_data = dt[2];
            w1_req = rq[3]; w1_addr = ad[3]; w1_data = dt[3];
        end
        clear_reqs();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_read_arb();
        test_write_alternate();
        test_same_addr();
        test_spram_alternate();
        test_reset_during_read();
        test_random(1'b0, 10000);
        test_random(1'b1, 10000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cd_sdpram_arb.md
CD_SDPRAM_ARB -- requirements
Module: cd_sdpram_arb

Interface
REQ-001 Parameter A_WIDTH, default 8, RAM address width.
REQ-002 Parameter D_WIDTH, default 8, RAM data width.
REQ-003 Parameter SPRAM_ONLY, default 0; 1 = at most one RAM access per cycle (single-port backing RAM).
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 rN_req / rN_addr, N=0,1  in  1 / A_WIDTH  read request and address, held until granted.
REQ-007 rN_gnt  out  1  read accepted this cycle, combinational.
REQ-008 rN_vld  out  1  rd_data valid for client N, registered.
REQ-009 rd_data  out  D_WIDTH  shared read data, equals ram_rd.
REQ-010 wN_req / wN_addr / wN_data, N=0,1  in  1 / A_WIDTH / D_WIDTH  write request, address and data, held until granted.
REQ-011 wN_gnt  out  1  write accepted this cycle, combinational.
REQ-012 ram_cen / ram_wen  out  1 / 1  RAM chip enable and write enable, both active low.
REQ-013 ram_ra / ram_wa / ram_wd  out  A_WIDTH / A_WIDTH / D_WIDTH  RAM read address, write address and write data.
REQ-014 ram_rd  in  D_WIDTH  RAM read data, valid one cycle after the read edge.

Function
REQ-015 A request whose gnt is high shall be consumed at that rising edge; the client shall drop or change req/addr/data only after that edge.
REQ-016 Read arbitration: one requester -> grant it; both -> grant the client indicated by rprio; after each read grant, rprio <= index of the client not granted.
REQ-017 Write arbitration: identical to read arbitration, using independent bit wprio.
REQ-018 SPRAM_ONLY=0: one read grant and one write grant allowed in the same cycle.
REQ-019 SPRAM_ONLY=1: at most one grant per cycle; if a read and a write are both pending, bit rwprio selects (0 = write); rwprio flips after each contested cycle.
REQ-020 ram_cen = 0 iff any grant this cycle; ram_wen = 0 iff a write grant this cycle; otherwise 1.
REQ-021 ram_ra / ram_wa / ram_wd mux the granted client's fields; with no grant they hold client 0's fields (no functional effect).
REQ-022 Read latency: rN_vld is high exactly one cycle after rN_gnt, with rd_data = ram_rd in that cycle.
REQ-023 Same-address read and write granted in the same cycle (SPRAM_ONLY=0): read returns the pre-write data.
REQ-024 Back-to-back: a client holding req high is granted every cycle it wins; no bubble is inserted by the arbiter.
REQ-025 Starvation bound: a continuously requesting client is granted within 2 cycles (SPRAM_ONLY=0) or within 4 cycles (SPRAM_ONLY=1).
REQ-026 rN_gnt and rN_vld shall never be high for both read clients in the same cycle.

Reset
REQ-027 While reset=1: all gnt=0, ram_cen=1, ram_wen=1, rN_vld=0, rprio=0, wprio=0, rwprio=0.
REQ-028 A read granted in the cycle before reset asserts shall not raise rN_vld.
REQ-029 The first cycle after reset deasserts shall arbitrate normally with priority to client 0 and to writes.

Verification
REQ-030 After reset, r0 and r1 both request addresses 0x10 and 0x20 (RAM preloaded 0xA1/0xB2) -> r0_gnt in cycle 0, r1_gnt in cycle 1; r0_vld with 0xA1 in cycle 1, r1_vld with 0xB2 in cycle 2.
REQ-031 w0 and w1 both request continuously for 6 cycles -> grants alternate w0,w1,w0,...; ram_wen=0 every cycle.
REQ-032 SPRAM_ONLY=0, write 0x55 to 0x30 (old value 0x00) with a simultaneous read of 0x30 -> read returns 0x00; a read the next cycle returns 0x55.
REQ-033 SPRAM_ONLY=1, r0 and w0 both continuously requesting -> grants alternate w,r,w,r; never both in one cycle.
REQ-034 r0 granted, reset pulsed high on the next edge -> r0_vld stays 0; all outputs at their reset values while reset=1.
REQ-035 Random four-client traffic for 10k cycles against a reference memory model -> all read data matches and every request is granted within the REQ-025 bound.
